// File: rtl/prbs_checker.sv
// prbs_checker: locks onto the period-3 sequence s[n] = s[n-1] ^ s[n-2]
// (pattern 0,1,1) produced by the 3-stage PRBS generator, then flywheels
// on its own prediction and reports per-sample mismatches.
//
// Optional build macro: PRBS_CHECKER_ERRCNT_EN
//   defined   -> saturating mismatch counter err_count_o with synchronous clr_i
//   undefined -> err_count_o tied to zero, clr_i ignored
//
// state  | meaning
// HUNT   | filling the 2-bit history; all-zero history is rejected
// SYNC   | history nonzero, counting consecutive correct predictions
// LOCKED | flywheeling on the prediction, counting consecutive misses
module prbs_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned CW         = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ena_i,
  input  logic          in_i,
  input  logic          clr_i,
  output logic          locked_o,
  output logic          err_o,
  output logic [CW-1:0] err_count_o
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_TC = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_TC = 4'(LOSS_COUNT);

  state_e     state_q;
  logic [1:0] h_q;          // h_q[0] newest bit, h_q[1] previous bit
  logic [1:0] fill_q;
  logic [3:0] match_cnt_q;
  logic [3:0] miss_cnt_q;
  logic       locked_q;
  logic       err_q;

  logic       pred;
  logic       mismatch;
  logic [1:0] h_in_d;
  logic [1:0] h_fly_d;
  logic [1:0] fill_inc_d;
  logic [3:0] match_inc_d;
  logic [3:0] miss_inc_d;

  assign pred        = h_q[0] ^ h_q[1];
  assign mismatch    = in_i ^ pred;
  assign h_in_d      = {h_q[0], in_i};
  // In LOCKED the history advances on the prediction, so a corrupted bit
  // never poisons later predictions.
  assign h_fly_d     = {h_q[0], pred};
  assign fill_inc_d  = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
  assign match_inc_d = match_cnt_q + 4'd1;
  assign miss_inc_d  = miss_cnt_q + 4'd1;

  // Sync FSM: history, fill, run counters and registered locked/err outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HUNT;
      h_q         <= 2'b00;
      fill_q      <= 2'd0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (ena_i) begin
        unique case (state_q)
          HUNT: begin
            h_q    <= h_in_d;
            fill_q <= fill_inc_d;
            if (fill_inc_d == 2'd2 && h_in_d != 2'b00) begin
              state_q     <= SYNC;
              match_cnt_q <= 4'd0;
            end
          end
          SYNC: begin
            h_q <= h_in_d;
            if (!mismatch) begin
              if (match_inc_d == LOCK_TC) begin
                state_q     <= LOCKED;
                match_cnt_q <= 4'd0;
                miss_cnt_q  <= 4'd0;
                locked_q    <= 1'b1;
              end else begin
                match_cnt_q <= match_inc_d;
              end
            end else begin
              // Keep the fresh bit: history is already full, so retry SYNC
              // on the very next sample if it is nonzero.
              state_q <= HUNT;
              fill_q  <= 2'd2;
            end
          end
          LOCKED: begin
            h_q <= h_fly_d;
            if (mismatch) begin
              err_q <= 1'b1;
              if (miss_inc_d == LOSS_TC) begin
                state_q    <= HUNT;
                fill_q     <= 2'd0;
                miss_cnt_q <= 4'd0;
                locked_q   <= 1'b0;
              end else begin
                miss_cnt_q <= miss_inc_d;
              end
            end else begin
              miss_cnt_q <= 4'd0;
            end
          end
          default: begin
            state_q  <= HUNT;
            fill_q   <= 2'd0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked_o = locked_q;
  assign err_o    = err_q;

`ifdef PRBS_CHECKER_ERRCNT_EN
  logic [CW-1:0] err_count_q;
  logic          count_err;

  assign count_err = ena_i && (state_q == LOCKED) && mismatch;

  // Saturating mismatch counter; clear has priority over a same-edge count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_q <= '0;
    end else if (clr_i) begin
      err_count_q <= '0;
    end else if (count_err && err_count_q != {CW{1'b1}}) begin
      err_count_q <= err_count_q + CW'(1);
    end
  end

  assign err_count_o = err_count_q;
`else
  logic unused_clr;
  assign unused_clr  = clr_i;
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker (LOCK_COUNT=4, LOSS_COUNT=3, CW=2).
// Expected err_count follows PRBS_CHECKER_ERRCNT_EN: zero when undefined.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       din = 1'b0;
  logic       clr = 1'b0;
  logic       locked;
  logic       err;
  logic [1:0] cnt;

  always #5 clk = ~clk;

  prbs_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CW(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ena_i      (ena),
    .in_i       (din),
    .clr_i      (clr),
    .locked_o   (locked),
    .err_o      (err),
    .err_count_o(cnt)
  );

  typedef struct {
    int         idx;
    logic       lk;
    logic       er;
    logic [1:0] cn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step_n = 0;

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", nm, idx, act, req);
    end
  endtask

  function automatic logic [1:0] ec(int c);
`ifdef PRBS_CHECKER_ERRCNT_EN
    return 2'(c);
`else
    return 2'(c & 0);
`endif
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(bit e, bit d, bit c, bit lk, bit er, int cn);
    exp_t x;
    @(negedge clk);
    ena = e;
    din = d;
    clr = c;
    step_n++;
    x.idx = step_n;
    x.lk  = lk;
    x.er  = er;
    x.cn  = ec(cn);
    exp_q.push_back(x);
  endtask

  task automatic drain();
    @(negedge clk);
    ena = 1'b0;
    clr = 1'b0;
    chk("drain", step_n, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rst_check(string nm);
    chk({nm, "_locked"}, step_n, 32'(locked), 32'd0);
    chk({nm, "_err"}, step_n, 32'(err), 32'd0);
    chk({nm, "_cnt"}, step_n, 32'(cnt), 32'd0);
  endtask

  task automatic async_reset(string nm);
    #2 rst_n = 1'b0;
    #1 rst_check(nm);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: outputs are compared #1 after every edge that has an expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("locked", x.idx, 32'(locked), 32'(x.lk));
      chk("err", x.idx, 32'(err), 32'(x.er));
      chk("err_count", x.idx, 32'(cnt), 32'(x.cn));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog step=%0d actual=timeout required=finish", step_n);
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire: lock only after 2 + LOCK_COUNT samples
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);

    // Single bad bit; flywheel keeps predicting
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 1, 0, 1, 0, 1);
    step(1, 1, 0, 1, 0, 1);

    // ena low freezes state even with a wrong bit on the line
    step(0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);

    // Interleaved misses: saturate at 3, then clr with a mismatch
    step(1, 0, 0, 1, 1, 2);
    step(1, 1, 0, 1, 0, 2);
    step(1, 1, 0, 1, 1, 3);
    step(1, 1, 0, 1, 0, 3);
    step(1, 0, 0, 1, 1, 3);
    step(1, 0, 0, 1, 0, 3);
    step(1, 0, 0, 1, 1, 3);
    step(1, 1, 0, 1, 0, 3);
    step(1, 1, 1, 1, 1, 0);
    step(1, 1, 0, 1, 0, 0);

    // Three consecutive misses drop lock, then full reacquire from fill 0
    step(1, 0, 0, 1, 1, 1);
    step(1, 1, 0, 1, 1, 2);
    step(1, 0, 0, 0, 1, 3);
    step(1, 0, 0, 0, 0, 3);
    step(1, 1, 0, 0, 0, 3);
    step(1, 1, 0, 0, 0, 3);
    step(1, 0, 0, 0, 0, 3);
    step(1, 1, 0, 0, 0, 3);
    step(1, 1, 0, 1, 0, 3);
    drain();

    // Async reset while locked, then all-zero input is never accepted
    async_reset("async_rst");
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    drain();

    // SYNC mismatch keeps history full: retry SYNC on the next sample
    async_reset("rst2");
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive matches in SYNC needed to declare lock (range 1..15).
REQ-002 Parameter LOSS_COUNT, default 3: consecutive mismatches in LOCKED that drop lock (range 1..15).
REQ-003 Parameter CW, default 8: width of the error counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  sample qualifier; a bit is consumed only on a rising edge with ena=1.
REQ-007 in  input  1  serial received bit; the output of the team's 3-stage PRBS generator.
REQ-008 clr  input  1  synchronous clear of err_count; does not affect lock state.
REQ-009 locked  output  1  registered; high while the FSM is in LOCKED.
REQ-010 err  output  1  registered one-cycle pulse per mismatched sample while LOCKED.
REQ-011 err_count  output  CW  registered saturating count of mismatches seen while LOCKED.

Function
REQ-012 Reference sequence SHALL be s[n] = s[n-1] XOR s[n-2], period 3 for nonzero state; repeating pattern 0,1,1.
REQ-013 Block SHALL keep a 2-bit history h (h0 = newest, h1 = previous), a fill count (0..2), and predicted bit p = h0 XOR h1.
REQ-014 FSM SHALL have three states, HUNT, SYNC and LOCKED; it evaluates only on ena=1 edges and holds all state when ena=0.
REQ-015 HUNT: shift in into h and increment fill; when fill reaches 2 with h != 00, go to SYNC with match_cnt = 0.
REQ-016 HUNT, h = 00 at fill 2 (lock-up pattern): stay in HUNT and keep shifting.
REQ-017 SYNC: in == p increments match_cnt and shifts in; at match_cnt == LOCK_COUNT, go to LOCKED with miss_cnt = 0.
REQ-018 SYNC: in != p returns to HUNT, with h = {previous h0, in} and fill = 2.
REQ-019 LOCKED: h shifts in p rather than in (flywheel), so a single bit error does not corrupt prediction.
REQ-020 LOCKED mismatch: set err for one cycle, increment err_count (saturating at 2^CW-1), and increment miss_cnt.
REQ-021 LOCKED match: clear miss_cnt.
REQ-022 LOCKED, miss_cnt reaching LOSS_COUNT: go to HUNT with fill = 0, and deassert locked on the same edge.
REQ-023 locked and err SHALL change on the same rising edge that consumes the qualifying sample, i.e. they are visible in the following cycle.
REQ-024 err SHALL be low on every cycle with ena=0 and in every state other than LOCKED.
REQ-025 clr together with a counted mismatch on the same edge: the clear wins and err_count = 0; err still pulses.
REQ-026 Saturation: a mismatch at err_count = all-ones leaves err_count unchanged and still pulses err.

Reset
REQ-027 When rst=0, the block SHALL asynchronously set FSM = HUNT, h = 00, fill = 0, match_cnt = 0, miss_cnt = 0, locked = 0, err = 0 and err_count = 0.
REQ-028 Reset asserted mid-operation SHALL abort any lock immediately; after release, first lock requires 2 + LOCK_COUNT qualified samples.

Configuration
REQ-029 Macro PRBS_CHECKER_ERRCNT_EN defined: err_count and clr SHALL behave per REQ-011, REQ-020, REQ-025 and REQ-026.
REQ-030 Macro PRBS_CHECKER_ERRCNT_EN undefined: no counter is built, err_count SHALL be constant 0, and clr is ignored; locked and err are unchanged.

Verification
REQ-031 Reset, then ena=1 with in = 0,1,1,0,1,1 -> locked = 0 through sample 5, locked = 1 the cycle after sample 6, err never pulses.
REQ-032 Locked, then feed 0,1,0(bad),0,1,1 -> exactly one err pulse, err_count = 1, locked stays 1, and the flywheel keeps predicting correctly.
REQ-033 Locked, then three consecutive wrong bits -> three err pulses, err_count = 3, locked = 0 the cycle after the 3rd, and the FSM is in HUNT.
REQ-034 Reset, then constant in = 0 for 20 samples -> locked stays 0 and err_count = 0 (lock-up pattern rejected).
REQ-035 CW=2, locked, 5 mismatches interleaved with matches so lock is not lost -> err_count saturates at 3; pulse clr together with a mismatch -> err_count = 0 and err = 1.
REQ-036 Locked stream with ena toggling 1,0,0,1 plus rst=0 mid-stream -> state frozen while ena=0; reset zeroes all outputs asynchronously, without a clock edge.
